// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_pkg: shared state encoding, header/timeout defaults and checksum helper
package uart_cmd_pkg;
    typedef enum logic [2:0] {HUNT0, HUNT1, CMD, LEN, PAYLOAD, CSUM} state_t;
    localparam logic [7:0] HDR0_DEF    = 8'h55;
    localparam logic [7:0] HDR1_DEF    = 8'hAA;
    localparam int         TIMEOUT_DEF = 50000;
    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction
endpackage

// File: rtl/uart_cmd_parser_timer.sv
// uart_frame_timer: inter-byte watchdog with a single-cycle terminal-count pulse
module uart_frame_timer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    // A clear in the terminal cycle suppresses the pulse: the arriving byte wins.
    always_comb begin
        tc    = enable && !clear && (cnt_q == W'(TIMEOUT_CYCLES - 1));
        cnt_d = (clear || !enable || tc) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames UART bytes into checksummed command words
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN        = 8,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [7:0] HDR0           = HDR0_DEF,
    parameter logic [7:0] HDR1           = HDR1_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_int,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_code,
    output logic [3:0]           cmd_len,
    output logic [8*MAX_LEN-1:0] cmd_payload,
    output logic                 frame_err,
    output logic                 busy
);
    state_t               state_q, state_d;
    logic                 rx_int_q, byte_stb, tc;
    logic [7:0]           sum_q, sum_d, code_q, code_d, cmd_code_q, cmd_code_d;
    logic [3:0]           idx_q, idx_d, len_q, len_d, cmd_len_q, cmd_len_d;
    logic [8*MAX_LEN-1:0] shadow_q, shadow_d, cmd_payload_q, cmd_payload_d;
    logic                 valid_q, valid_d, err_q, err_d, busy_q;
    assign byte_stb = rx_int_q & ~rx_int;
    uart_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (byte_stb),
        .enable (state_q != HUNT0),
        .tc     (tc)
    );
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        len_d    = len_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (byte_stb) begin
            case (state_q)
                HUNT0: state_d = (rx_data == HDR0) ? HUNT1 : HUNT0;
                HUNT1: begin
                    state_d  = (rx_data == HDR1) ? CMD : (rx_data == HDR0) ? HUNT1 : HUNT0;
                    shadow_d = (rx_data == HDR1) ? '0 : shadow_q;
                end
                CMD: begin
                    code_d  = rx_data;
                    sum_d   = rx_data;
                    state_d = LEN;
                end
                LEN: begin
                    sum_d   = csum_add(sum_q, rx_data);
                    len_d   = rx_data[3:0];
                    idx_d   = '0;
                    err_d   = rx_data > 8'(MAX_LEN);
                    state_d = err_d ? HUNT0 : (rx_data == 8'd0) ? CSUM : PAYLOAD;
                end
                PAYLOAD: begin
                    for (int i = 0; i < MAX_LEN; i++)
                        if (idx_q == 4'(i)) shadow_d[8*i +: 8] = rx_data;
                    sum_d   = csum_add(sum_q, rx_data);
                    idx_d   = idx_q + 4'd1;
                    state_d = (idx_d == len_q) ? CSUM : PAYLOAD;
                end
                CSUM: begin
                    valid_d = rx_data == sum_q;
                    err_d   = !valid_d;
                    state_d = HUNT0;
                end
                default: state_d = HUNT0;
            endcase
        end else if (tc) begin
            // A half-seen header is not a frame, so it dies silently.
            err_d   = state_q != HUNT1;
            state_d = HUNT0;
        end
        cmd_code_d    = valid_d ? code_q : cmd_code_q;
        cmd_len_d     = valid_d ? len_q : cmd_len_q;
        cmd_payload_d = valid_d ? shadow_q : cmd_payload_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_int_q      <= 1'b0;
            state_q       <= HUNT0;
            sum_q         <= '0;
            idx_q         <= '0;
            len_q         <= '0;
            code_q        <= '0;
            shadow_q      <= '0;
            cmd_code_q    <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_int_q      <= rx_int;
            state_q       <= state_d;
            sum_q         <= sum_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            cmd_code_q    <= cmd_code_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            busy_q        <= state_d != HUNT0;
        end
    assign cmd_valid   = valid_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;
    assign cmd_code    = cmd_code_q;
    assign cmd_len     = cmd_len_q;
    assign cmd_payload = cmd_payload_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frames checked against a byte-queue model
module tb_uart_cmd_parser;
    localparam int MAX_LEN = 8;
    localparam int T       = 40;
    logic                 clk = 1'b0, rst = 1'b1, rx_int = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic                 cmd_valid, frame_err, busy;
    logic [7:0]           cmd_code;
    logic [3:0]           cmd_len;
    logic [8*MAX_LEN-1:0] cmd_payload;
    int errors = 0, checks = 0, n_valid = 0, n_err = 0;
    always #5 clk = ~clk;
    uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(T), .HDR0(8'h55), .HDR1(8'hAA)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_int      (rx_int),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .frame_err   (frame_err),
        .busy        (busy)
    );
    // Model: mode 0 = no header, 1 = saw 0x55, 2 = collecting bytes after the header into fr.
    int           cyc = 0, last = 0, mode = 0;
    bit           prev = 1'b0, m_valid = 1'b0, m_err = 1'b0;
    byte unsigned fr[$];
    byte unsigned tx[$];
    logic [7:0]   m_code = 8'h00;
    logic [3:0]   m_len = 4'h0;
    logic [63:0]  m_pay = 64'h0;
    task automatic model_step();
        bit stb;
        byte unsigned b, s;
        int n;
        cyc++;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            mode = 0; prev = 1'b0; m_code = 8'h00; m_len = 4'h0; m_pay = 64'h0; fr.delete();
            return;
        end
        stb  = prev && !rx_int;
        prev = rx_int;
        b    = rx_data;
        if (stb) begin
            last = cyc;
            if (mode == 0) mode = (b == 8'h55) ? 1 : 0;
            else if (mode == 1) begin
                if (b == 8'hAA) begin mode = 2; fr.delete(); end
                else if (b != 8'h55) mode = 0;
            end else begin
                fr.push_back(b);
                n = fr.size();
                if (n == 2 && fr[1] > MAX_LEN) begin m_err = 1'b1; mode = 0; end
                else if (n >= 2 && n == int'(fr[1]) + 3) begin
                    s = 8'h00;
                    for (int i = 0; i < n - 1; i++) s += fr[i];
                    if (s == fr[n-1]) begin
                        m_valid = 1'b1; m_code = fr[0]; m_len = 4'(fr[1]); m_pay = 64'h0;
                        for (int i = 0; i < int'(fr[1]); i++) m_pay[8*i +: 8] = fr[2+i];
                    end else m_err = 1'b1;
                    mode = 0;
                end
            end
        end else if (mode != 0 && cyc - last == T) begin
            m_err = (mode == 2);
            mode  = 0;
        end
    endtask
    initial forever begin
        @(posedge clk);
        model_step();
    end
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            checks++;
            if ({cmd_valid, frame_err, busy, cmd_code, cmd_len, cmd_payload} !==
                {m_valid, m_err, mode != 0, m_code, m_len, m_pay}) begin
                errors++;
                $display("FAIL cycle %0d: dut v=%b e=%b busy=%b code=%h len=%0d pay=%h, want v=%b e=%b busy=%b code=%h len=%0d pay=%h",
                         cyc, cmd_valid, frame_err, busy, cmd_code, cmd_len, cmd_payload,
                         m_valid, m_err, mode != 0, m_code, m_len, m_pay);
            end
            n_valid += int'(cmd_valid);
            n_err   += int'(frame_err);
        end
    end
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(byte unsigned b, int gap);
        rx_int = 1'b1;
        repeat (2) @(negedge clk);
        rx_int  = 1'b0;
        rx_data = b;
        @(negedge clk);
        rx_data = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask
    task automatic send_tx();
        foreach (tx[i]) send(tx[i], $urandom_range(1, 8));
    endtask
    task automatic rand_frame();
        int kind, len, cut;
        byte unsigned c, s, b;
        kind = $urandom_range(0, 9);
        len  = $urandom_range(0, MAX_LEN);
        c    = 8'($urandom);
        tx.delete();
        if (kind == 2) repeat ($urandom_range(1, 4)) tx.push_back(8'($urandom));
        if (kind == 4) tx.push_back(8'h55);
        tx.push_back(8'h55); tx.push_back(8'hAA); tx.push_back(c);
        if (kind == 1) begin
            tx.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            send_tx();
            return;
        end
        tx.push_back(8'(len));
        s = c + 8'(len);
        for (int i = 0; i < len; i++) begin
            b = ($urandom_range(0, 5) == 0) ? 8'h55 : 8'($urandom);
            tx.push_back(b);
            s += b;
        end
        tx.push_back(kind == 0 ? s + 8'd1 : s);
        if (kind == 3 || kind == 9) begin
            cut = $urandom_range(1, tx.size() - 1);
            while (tx.size() > cut) void'(tx.pop_back());
        end
        send_tx();
        if (kind == 3) idle(T - 3 + $urandom_range(0, 6));
        if (kind == 9) begin rst = 1'b1; idle(2); rst = 1'b0; idle(1); end
    endtask
    int v0, e0;
    initial begin
        idle(3);
        chk("reset_valid", cmd_valid, 0); chk("reset_err", frame_err, 0); chk("reset_busy", busy, 0);
        chk("reset_code", cmd_code, 0); chk("reset_len", cmd_len, 0); chk("reset_payload", cmd_payload, 0);
        rst = 1'b0;
        idle(2);
        v0 = n_valid; e0 = n_err;
        tx = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h12, 8'h34, 8'h58}; send_tx(); idle(3);
        chk("good_valid_cnt", n_valid - v0, 1); chk("good_err_cnt", n_err - e0, 0);
        chk("good_code", cmd_code, 64'h10); chk("good_len", cmd_len, 2); chk("good_payload", cmd_payload, 64'h3412);
        v0 = n_valid; e0 = n_err;
        tx = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h12, 8'h34, 8'h59}; send_tx(); idle(3);
        chk("badsum_err_cnt", n_err - e0, 1); chk("badsum_valid_cnt", n_valid - v0, 0);
        chk("badsum_code_hold", cmd_code, 64'h10); chk("badsum_payload_hold", cmd_payload, 64'h3412);
        e0 = n_err;
        tx = '{8'h55, 8'hAA, 8'h10}; send_tx(); send(8'h09, 1);
        chk("len_err_pulse", frame_err, 1);
        idle(2);
        chk("len_err_cnt", n_err - e0, 1); chk("len_err_busy", busy, 0);
        v0 = n_valid;
        tx = '{8'h55, 8'hAA, 8'h33, 8'h01, 8'h07, 8'h3B}; send_tx(); idle(3);
        chk("after_len_valid_cnt", n_valid - v0, 1); chk("after_len_code", cmd_code, 64'h33);
        chk("after_len_payload", cmd_payload, 64'h07);
        e0 = n_err;
        tx = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h12}; send_tx(); idle(T + 5);
        chk("timeout_err_cnt", n_err - e0, 1); chk("timeout_busy", busy, 0);
        e0 = n_err;
        send(8'h55, 2); idle(T + 5);
        chk("hunt1_timeout_err_cnt", n_err - e0, 0); chk("hunt1_timeout_busy", busy, 0);
        v0 = n_valid; e0 = n_err;
        tx = '{8'h55, 8'hAA, 8'h10, 8'h02}; send_tx(); send(8'h12, T - 2); send(8'h34, 3); send(8'h58, 3); idle(3);
        chk("terminal_byte_valid_cnt", n_valid - v0, 1); chk("terminal_byte_err_cnt", n_err - e0, 0);
        v0 = n_valid; e0 = n_err;
        tx = '{8'h55, 8'hAA, 8'h10, 8'h02}; send_tx(); send(8'h12, T - 1); send(8'h34, 3); send(8'h58, 3); idle(3);
        chk("late_byte_err_cnt", n_err - e0, 1); chk("late_byte_valid_cnt", n_valid - v0, 0);
        v0 = n_valid;
        tx = '{8'h55, 8'h55, 8'hAA, 8'h20, 8'h00, 8'h20}; send_tx(); idle(3);
        chk("resync_valid_cnt", n_valid - v0, 1); chk("resync_code", cmd_code, 64'h20);
        chk("resync_len", cmd_len, 0); chk("resync_payload", cmd_payload, 0);
        v0 = n_valid; e0 = n_err;
        tx = '{8'h55, 8'hAA, 8'h10}; send_tx();
        rst = 1'b1; idle(2);
        chk("midrst_code", cmd_code, 0); chk("midrst_busy", busy, 0); chk("midrst_valid", cmd_valid, 0);
        rst = 1'b0; idle(2);
        tx = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h12, 8'h34, 8'h58}; send_tx(); idle(3);
        chk("postrst_valid_cnt", n_valid - v0, 1); chk("postrst_err_cnt", n_err - e0, 0);
        chk("postrst_code", cmd_code, 64'h10); chk("postrst_payload", cmd_payload, 64'h3412);
        repeat (150) rand_frame();
        idle(T + 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
